// File: rtl/exp_adjust_pipe.sv
// exp_adjust_pipe
//   Two-stage exponent adjuster placed between the normaliser/leading-zero
//   stage and the rounder/packer.
//
//   Stage 1 forms a signed, two-bit-wider result r from the biased exponent E:
//     selection=1           : r = E - L_shift_value
//     selection=0, L_or_R=00: r = E - 1
//     selection=0, L_or_R=01: r = E + 1
//     selection=0, L_or_R=1x: r = E
//   Stage 2 clamps r into the exponent range:
//     r >= all-ones         : Ez_pre = all-ones, ovf=1
//     r <= 0                : Ez_pre = 0,        unf=1
//     otherwise             : Ez_pre = r[EXP_W-1:0]
//
// Ports
//   CLK, RST        clock, synchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready is combinational on out_ready)
//   E, L_shift_value, selection, L_or_R   operand and mode
//   out_valid/out_ready   output handshake
//   Ez_pre, ovf, unf      clamped exponent and saturation flags
//   cnt_clr               synchronous clear of both event counters (wins over count)
//   ovf_cnt, unf_cnt      saturating counts of transferred ovf / unf results

module exp_adjust_pipe #(
   parameter int unsigned EXP_W   = 8,
   parameter int unsigned SHIFT_W = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [EXP_W-1:0]   E,
   input  logic [SHIFT_W-1:0] L_shift_value,
   input  logic               selection,
   input  logic [1:0]         L_or_R,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [EXP_W-1:0]   Ez_pre,
   output logic               ovf,
   output logic               unf,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   ovf_cnt,
   output logic [CNT_W-1:0]   unf_cnt
);

   localparam int unsigned R_W = EXP_W + 2;

   logic             s1_valid;
   logic [R_W-1:0]   s1_r;
   logic [R_W-1:0]   r_next;
   logic [R_W-1:0]   e_ext;
   logic [R_W-1:0]   sh_ext;
   logic             s1_adv;
   logic             s2_adv;
   logic             out_xfer;

   logic [EXP_W-1:0] ez_next;
   logic             ovf_next;
   logic             unf_next;

   // Sign bit of r is the MSB; the extra two bits leave room for E+1 above
   // all-ones and for E minus the largest shift below zero.
   localparam logic [R_W-1:0] SAT_MAX = {2'b00, {EXP_W{1'b1}}};

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign out_xfer = out_valid && out_ready;

   assign e_ext  = {2'b00, E};
   assign sh_ext = R_W'(L_shift_value);

   always_comb begin
      r_next = e_ext;
      if (selection) begin
         r_next = e_ext - sh_ext;
      end else begin
         case (L_or_R)
            2'b00:   r_next = e_ext - R_W'(1);
            2'b01:   r_next = e_ext + R_W'(1);
            default: r_next = e_ext;
         endcase
      end
   end

   always_comb begin
      ez_next  = s1_r[EXP_W-1:0];
      ovf_next = 1'b0;
      unf_next = 1'b0;
      if ($signed(s1_r) >= $signed(SAT_MAX)) begin
         ez_next  = '1;
         ovf_next = 1'b1;
      end else if (s1_r[R_W-1] || (s1_r == '0)) begin
         ez_next  = '0;
         unf_next = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         s1_valid  <= 1'b0;
         s1_r      <= '0;
         out_valid <= 1'b0;
         Ez_pre    <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_r <= r_next;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               Ez_pre <= ez_next;
               ovf    <= ovf_next;
               unf    <= unf_next;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST || cnt_clr) begin
         ovf_cnt <= '0;
         unf_cnt <= '0;
      end else begin
         if (out_xfer && ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
         end
         if (out_xfer && unf && (unf_cnt != '1)) begin
            unf_cnt <= unf_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_exp_adjust_pipe.sv
module tb_exp_adjust_pipe;

   logic       clk = 1'b0;
   logic       RST;
   logic       in_valid;
   logic [7:0] E;
   logic [4:0] L_shift_value;
   logic       selection;
   logic [1:0] L_or_R;
   logic       out_ready;
   logic       cnt_clr;

   logic        in_ready, out_valid, ovf, unf;
   logic [7:0]  Ez_pre;
   logic [15:0] ovf_cnt, unf_cnt;

   logic        in_ready_s, out_valid_s, ovf_s, unf_s;
   logic [7:0]  Ez_s;
   logic [1:0]  ovf_cnt_s, unf_cnt_s;

   always #5 clk = ~clk;

   exp_adjust_pipe #(.EXP_W(8), .SHIFT_W(5), .CNT_W(16)) dut (
      .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .E(E), .L_shift_value(L_shift_value), .selection(selection), .L_or_R(L_or_R),
      .out_valid(out_valid), .out_ready(out_ready), .Ez_pre(Ez_pre),
      .ovf(ovf), .unf(unf), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
   );

   exp_adjust_pipe #(.EXP_W(8), .SHIFT_W(5), .CNT_W(2)) sat (
      .CLK(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready_s),
      .E(E), .L_shift_value(L_shift_value), .selection(selection), .L_or_R(L_or_R),
      .out_valid(out_valid_s), .out_ready(out_ready), .Ez_pre(Ez_s),
      .ovf(ovf_s), .unf(unf_s), .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt_s), .unf_cnt(unf_cnt_s)
   );

   typedef struct {
      logic [7:0] ez;
      logic       ov;
      logic       un;
   } exp_t;

   typedef struct {
      logic [7:0] e;
      logic       sel;
      logic [4:0] sh;
      logic [1:0] lr;
      logic [7:0] ez;
      logic       ov;
      logic       un;
   } vec_t;

   exp_t sb[$];
   exp_t mon_x;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:0] e, input logic sel,
                                  input logic [4:0] sh, input logic [1:0] lr);
      exp_t x;
      int   r;
      r = int'(e);
      if (sel)             r = r - int'(sh);
      else if (lr == 2'b00) r = r - 1;
      else if (lr == 2'b01) r = r + 1;
      x.ez = r[7:0];
      x.ov = 1'b0;
      x.un = 1'b0;
      if (r >= 255) begin
         x.ez = 8'd255;
         x.ov = 1'b1;
      end else if (r <= 0) begin
         x.ez = 8'd0;
         x.un = 1'b1;
      end
      return x;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the input was accepted.
   task automatic send(input logic [7:0] e, input logic sel, input logic [4:0] sh,
                       input logic [1:0] lr, input exp_t x);
      int unsigned n = 0;
      bit          done = 1'b0;
      E = e; selection = sel; L_shift_value = sh; L_or_R = lr; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(x);
            done = 1'b1;
         end else if (++n > 200) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (RST && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output actual=%0d required=none (t=%0t)", Ez_pre, $time);
         end else begin
            mon_x = sb.pop_front();
            chk("out_ez",  32'(Ez_pre), 32'(mon_x.ez));
            chk("out_ovf", 32'(ovf),    32'(mon_x.ov));
            chk("out_unf", 32'(unf),    32'(mon_x.un));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   vec_t vt[14];
   bit   rdone;

   initial begin
      vt[0]  = '{8'd100, 1'b1, 5'd5,  2'b01, 8'd95,  1'b0, 1'b0};
      vt[1]  = '{8'd100, 1'b0, 5'd31, 2'b00, 8'd99,  1'b0, 1'b0};
      vt[2]  = '{8'd100, 1'b0, 5'd7,  2'b01, 8'd101, 1'b0, 1'b0};
      vt[3]  = '{8'd100, 1'b0, 5'd3,  2'b11, 8'd100, 1'b0, 1'b0};
      vt[4]  = '{8'd254, 1'b0, 5'd0,  2'b01, 8'd255, 1'b1, 1'b0};
      vt[5]  = '{8'd3,   1'b1, 5'd3,  2'b01, 8'd0,   1'b0, 1'b1};
      vt[6]  = '{8'd2,   1'b1, 5'd31, 2'b10, 8'd0,   1'b0, 1'b1};
      vt[7]  = '{8'd1,   1'b0, 5'd0,  2'b00, 8'd0,   1'b0, 1'b1};
      vt[8]  = '{8'd255, 1'b0, 5'd0,  2'b10, 8'd255, 1'b1, 1'b0};
      vt[9]  = '{8'd254, 1'b0, 5'd9,  2'b10, 8'd254, 1'b0, 1'b0};
      vt[10] = '{8'd1,   1'b0, 5'd0,  2'b11, 8'd1,   1'b0, 1'b0};
      vt[11] = '{8'd0,   1'b0, 5'd0,  2'b10, 8'd0,   1'b0, 1'b1};
      vt[12] = '{8'd255, 1'b1, 5'd0,  2'b00, 8'd255, 1'b1, 1'b0};
      vt[13] = '{8'd40,  1'b1, 5'd31, 2'b00, 8'd9,   1'b0, 1'b0};

      RST = 1'b0; in_valid = 1'b0; E = '0; L_shift_value = '0; selection = 1'b0;
      L_or_R = 2'b10; out_ready = 1'b1; cnt_clr = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ez",        32'(Ez_pre),    32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      chk("rst_unf",       32'(unf),       32'd0);
      chk("rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
      chk("rst_unf_cnt",   32'(unf_cnt),   32'd0);
      chk("rst_sat_valid", 32'(out_valid_s | ovf_s | unf_s), 32'd0);
      chk("rst_sat_ez",    32'(Ez_s),      32'd0);
      chk("rst_sat_cnt",   32'({ovf_cnt_s, unf_cnt_s}), 32'd0);
      @(posedge clk); #1 RST = 1'b1;
      @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_in_ready_s", 32'(in_ready_s), 32'd1);
      @(posedge clk); #1;

      // latency: accepted at edge 1, out_valid after edge 2
      E = 8'd100; selection = 1'b1; L_shift_value = 5'd5; L_or_R = 2'b01; in_valid = 1'b1;
      @(negedge clk);
      chk("lat_in_ready", 32'(in_ready), 32'd1);
      sb.push_back('{8'd95, 1'b0, 1'b0});
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      drain();

      // table vectors, back to back
      for (int i = 0; i < 14; i++)
         send(vt[i].e, vt[i].sel, vt[i].sh, vt[i].lr, '{vt[i].ez, vt[i].ov, vt[i].un});
      drain();

      // counters: 5 ovf, 2 unf
      cnt_clr = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
      for (int i = 0; i < 3; i++) send(8'd255, 1'b0, 5'd0, 2'b10, '{8'd255, 1'b1, 1'b0});
      for (int i = 0; i < 2; i++) send(8'd254, 1'b0, 5'd0, 2'b01, '{8'd255, 1'b1, 1'b0});
      send(8'd0, 1'b0, 5'd0, 2'b00, '{8'd0, 1'b0, 1'b1});
      send(8'd5, 1'b1, 5'd20, 2'b11, '{8'd0, 1'b0, 1'b1});
      drain();
      chk("cnt_ovf5",      32'(ovf_cnt),   32'd5);
      chk("cnt_unf2",      32'(unf_cnt),   32'd2);
      chk("cnt_sat_ovf",   32'(ovf_cnt_s), 32'd3);
      chk("cnt_sat_unf",   32'(unf_cnt_s), 32'd2);

      // clear coinciding with an ovf transfer
      out_ready = 1'b0;
      send(8'd255, 1'b0, 5'd0, 2'b10, '{8'd255, 1'b1, 1'b0});
      for (int n = 0; n < 10 && !out_valid; n++) @(negedge clk);
      chk("clrx_held_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1 cnt_clr = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 cnt_clr = 1'b0;
      chk("clrx_ovf_cnt",   32'(ovf_cnt),   32'd0);
      chk("clrx_unf_cnt",   32'(unf_cnt),   32'd0);
      chk("clrx_sat_ovf",   32'(ovf_cnt_s), 32'd0);
      chk("clrx_no_dup",    32'(out_valid), 32'd0);

      // backpressure: 3-cycle stall on the first result
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(8'(10 + i), 1'b0, 5'd0, 2'b10, '{8'(10 + i), 1'b0, 1'b0});
         end
         begin
            int unsigned n = 0;
            while (!out_valid && n < 20) begin
               @(posedge clk); #1;
               n++;
            end
            chk("bp_first_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_stall_ez",       32'(Ez_pre),    32'd10);
               chk("bp_stall_valid",    32'(out_valid), 32'd1);
               chk("bp_stall_in_ready", 32'(in_ready),  32'd0);
               chk("bp_stall_flags",    32'({ovf, unf}), 32'd0);
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();

      // random stream with random backpressure
      rdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               logic [7:0] e;
               logic       sel;
               logic [4:0] sh;
               logic [1:0] lr;
               e   = 8'($urandom_range(0, 255));
               sel = 1'($urandom_range(0, 1));
               sh  = 5'($urandom_range(0, 31));
               lr  = 2'($urandom_range(0, 3));
               if (i % 7 == 0) e = 8'd254;
               if (i % 11 == 0) e = 8'd1;
               send(e, sel, sh, lr, model(e, sel, sh, lr));
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // reset with two transactions in flight and output stalled
      send(8'd255, 1'b0, 5'd0, 2'b01, '{8'd255, 1'b1, 1'b0});
      send(8'd1,   1'b0, 5'd0, 2'b00, '{8'd0,   1'b0, 1'b1});
      drain();
      chk("pre_rst_cnt_nonzero", 32'(ovf_cnt != 0 && unf_cnt != 0), 32'd1);
      out_ready = 1'b0;
      send(8'd20, 1'b0, 5'd0, 2'b10, '{8'd20, 1'b0, 1'b0});
      send(8'd21, 1'b0, 5'd0, 2'b10, '{8'd21, 1'b0, 1'b0});
      RST = 1'b0;
      sb.delete();
      @(posedge clk); #1 RST = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ovf_cnt",   32'(ovf_cnt),   32'd0);
      chk("mid_rst_unf_cnt",   32'(unf_cnt),   32'd0);
      chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1 out_ready = 1'b1;
      begin
         bit seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         chk("mid_rst_no_stale", 32'(seen), 32'd0);
      end

      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
